// File: rtl/lzy_scan_ctrl_if.sv
// Display-side bundle of the seven-segment scan controller: host controls in,
// scan drive and status out.
interface lzy_scan_ctrl_if;
    logic        En;
    logic        Load;
    logic [15:0] Data_in;
    logic [3:0]  Dp_in;
    logic        Lz_en;
    logic [7:0]  Seg;
    logic [3:0]  Dig_sel;
    logic [1:0]  Digit_idx;
    logic        Pending;
    logic        Frame_done;

    modport master (
        output En, Load, Data_in, Dp_in, Lz_en,
        input  Seg, Dig_sel, Digit_idx, Pending, Frame_done
    );

    modport slave (
        input  En, Load, Data_in, Dp_in, Lz_en,
        output Seg, Dig_sel, Digit_idx, Pending, Frame_done
    );
endinterface

// File: rtl/lzy_scan_ctrl.sv
// Four-digit multiplexed seven-segment scan controller with blanking between
// digits, frame-boundary double buffering and optional leading-zero blanking.
module lzy_scan_ctrl #(
    parameter int unsigned DIV       = 50000,
    parameter int unsigned BLANK_CYC = 2
) (
    input logic            Clk,
    input logic            Reset,
    lzy_scan_ctrl_if.slave bus
);
    localparam int unsigned MAX_CYC = (DIV > BLANK_CYC) ? DIV : BLANK_CYC;
    localparam int unsigned CNT_W   = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;
    localparam logic [CNT_W-1:0] DIV_LAST   = CNT_W'(DIV - 1);
    localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYC - 1);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] BLANK = 2'd1;
    localparam logic [1:0] SHOW  = 2'd2;

    logic [1:0]       state, state_d;
    logic [1:0]       idx, idx_d;
    logic [CNT_W-1:0] cnt, cnt_d;
    logic             frame_end;

    logic [15:0] act_data, shd_data;
    logic [3:0]  act_dp, shd_dp;
    logic        pending_q;

    logic [7:0]  seg_q, seg_d;
    logic [3:0]  dig_sel_q, dig_sel_d;
    logic [1:0]  digit_idx_q;
    logic        frame_done_q;

    logic [3:0]  nib;
    logic        lz_hit;

    function automatic logic [6:0] hex7(input logic [3:0] n);
        case (n)
            4'h0: hex7 = 7'h3F;
            4'h1: hex7 = 7'h06;
            4'h2: hex7 = 7'h5B;
            4'h3: hex7 = 7'h4F;
            4'h4: hex7 = 7'h66;
            4'h5: hex7 = 7'h6D;
            4'h6: hex7 = 7'h7D;
            4'h7: hex7 = 7'h07;
            4'h8: hex7 = 7'h7F;
            4'h9: hex7 = 7'h6F;
            4'hA: hex7 = 7'h77;
            4'hB: hex7 = 7'h7C;
            4'hC: hex7 = 7'h39;
            4'hD: hex7 = 7'h5E;
            4'hE: hex7 = 7'h79;
            default: hex7 = 7'h71;
        endcase
    endfunction

    // Next state, slot counter and the registered-output values for the next cycle
    always_comb begin
        state_d   = state;
        idx_d     = idx;
        cnt_d     = cnt;
        frame_end = 1'b0;
        seg_d     = 8'h00;
        dig_sel_d = 4'b1111;
        nib       = 4'h0;
        lz_hit    = 1'b0;

        if (!bus.En) begin
            state_d = IDLE;
            idx_d   = 2'd0;
            cnt_d   = '0;
        end else begin
            case (state)
                IDLE: begin
                    state_d = BLANK;
                    idx_d   = 2'd0;
                    cnt_d   = '0;
                end
                BLANK: begin
                    if (cnt == BLANK_LAST) begin
                        state_d = SHOW;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt + CNT_W'(1);
                    end
                end
                SHOW: begin
                    if (cnt == DIV_LAST) begin
                        state_d   = BLANK;
                        cnt_d     = '0;
                        idx_d     = idx + 2'd1;
                        frame_end = (idx == 2'd3);
                    end else begin
                        cnt_d = cnt + CNT_W'(1);
                    end
                end
                default: begin
                    state_d = IDLE;
                    idx_d   = 2'd0;
                    cnt_d   = '0;
                end
            endcase
        end

        nib = 4'(act_data >> {idx_d, 2'b00});
        case (idx_d)
            2'd3:    lz_hit = (act_data[15:12] == 4'h0);
            2'd2:    lz_hit = (act_data[15:8] == 8'h00);
            2'd1:    lz_hit = (act_data[15:4] == 12'h000);
            default: lz_hit = 1'b0;
        endcase

        if (state_d == SHOW) begin
            dig_sel_d = ~(4'b0001 << idx_d);
            seg_d     = {act_dp[idx_d], (bus.Lz_en && lz_hit) ? 7'h00 : hex7(nib)};
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state        <= IDLE;
            idx          <= 2'd0;
            cnt          <= '0;
            act_data     <= 16'h0000;
            act_dp       <= 4'h0;
            shd_data     <= 16'h0000;
            shd_dp       <= 4'h0;
            pending_q    <= 1'b0;
            seg_q        <= 8'h00;
            dig_sel_q    <= 4'b1111;
            digit_idx_q  <= 2'd0;
            frame_done_q <= 1'b0;
        end else begin
            state        <= state_d;
            idx          <= idx_d;
            cnt          <= cnt_d;
            seg_q        <= seg_d;
            dig_sel_q    <= dig_sel_d;
            digit_idx_q  <= idx_d;
            frame_done_q <= frame_end;

            // A coincident Load lands after the transfer, so the old shadow is shown
            if (pending_q && (frame_end || !bus.En)) begin
                act_data  <= shd_data;
                act_dp    <= shd_dp;
                pending_q <= 1'b0;
            end
            if (bus.Load) begin
                shd_data  <= bus.Data_in;
                shd_dp    <= bus.Dp_in;
                pending_q <= 1'b1;
            end
        end
    end

    assign bus.Seg        = seg_q;
    assign bus.Dig_sel    = dig_sel_q;
    assign bus.Digit_idx  = digit_idx_q;
    assign bus.Pending    = pending_q;
    assign bus.Frame_done = frame_done_q;
endmodule

// File: tb/tb_lzy_scan_ctrl.sv
// Directed bench for lzy_scan_ctrl with DIV=4, BLANK_CYC=1 (5-cycle digit slots,
// 20-cycle frames); expected segment bytes are hand-computed per frame.
module tb_lzy_scan_ctrl;
    logic Clk = 1'b0;
    logic Reset;

    lzy_scan_ctrl_if bus ();

    lzy_scan_ctrl #(.DIV(4), .BLANK_CYC(1)) dut (
        .Clk   (Clk),
        .Reset (Reset),
        .bus   (bus)
    );

    always #5 Clk = ~Clk;

    int n_chk = 0;
    int n_err = 0;
    logic tb_pend = 1'b0;

    int          ld_n = 0;
    int          ld_c0 = 0, ld_c1 = 0;
    logic [15:0] ld_v0 = '0, ld_v1 = '0;
    logic [3:0]  ld_p0 = '0, ld_p1 = '0;

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] want);
        n_chk++;
        assert (obs === want) else begin
            n_err++;
            $error("FAIL %s observed %h expected %h", tag, obs, want);
        end
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, " seg"}, 16'(bus.Seg), 16'h00);
        chk({tag, " dig_sel"}, 16'(bus.Dig_sel), 16'hF);
        chk({tag, " digit_idx"}, 16'(bus.Digit_idx), 16'h0);
        chk({tag, " pending"}, 16'(bus.Pending), 16'h0);
        chk({tag, " frame_done"}, 16'(bus.Frame_done), 16'h0);
    endtask

    // Runs n cycles of a frame; fd says whether the first edge is a frame boundary
    task automatic run_frame(input string tag, input logic [7:0] s0, input logic [7:0] s1,
                             input logic [7:0] s2, input logic [7:0] s3,
                             input logic fd, input int n);
        logic [31:0] sv;
        int d, p;
        sv = {s3, s2, s1, s0};
        for (int c = 0; c < n; c++) begin
            d = c / 5;
            p = c % 5;
            if (ld_n > 0 && c == ld_c0) begin
                bus.Load = 1'b1; bus.Data_in = ld_v0; bus.Dp_in = ld_p0;
            end else if (ld_n > 1 && c == ld_c1) begin
                bus.Load = 1'b1; bus.Data_in = ld_v1; bus.Dp_in = ld_p1;
            end
            tick();
            if (c == 0 && fd) tb_pend = 1'b0;
            if (bus.Load) tb_pend = 1'b1;
            bus.Load = 1'b0;
            chk($sformatf("%s c%0d dig_sel", tag, c), 16'(bus.Dig_sel),
                (p == 0) ? 16'hF : 16'(4'(~(4'b0001 << d))));
            chk($sformatf("%s c%0d seg", tag, c), 16'(bus.Seg),
                (p == 0) ? 16'h00 : 16'(sv[d*8 +: 8]));
            chk($sformatf("%s c%0d digit_idx", tag, c), 16'(bus.Digit_idx), 16'(d));
            chk($sformatf("%s c%0d frame_done", tag, c), 16'(bus.Frame_done),
                (c == 0) ? 16'(fd) : 16'h0);
            chk($sformatf("%s c%0d pending", tag, c), 16'(bus.Pending), 16'(tb_pend));
        end
        ld_n = 0;
    endtask

    initial begin
        Reset       = 1'b1;
        bus.En      = 1'b0;
        bus.Load    = 1'b0;
        bus.Data_in = 16'h0000;
        bus.Dp_in   = 4'h0;
        bus.Lz_en   = 1'b0;
        tick();
        tick();
        chk_reset("reset");

        Reset  = 1'b0;
        bus.En = 1'b1;
        run_frame("frA", 8'h3F, 8'h3F, 8'h3F, 8'h3F, 1'b0, 20);

        ld_n = 1; ld_c0 = 7; ld_v0 = 16'h1A2F; ld_p0 = 4'b0100;
        run_frame("frB", 8'h3F, 8'h3F, 8'h3F, 8'h3F, 1'b1, 20);

        ld_n = 2; ld_c0 = 3; ld_v0 = 16'h1111; ld_p0 = 4'h0;
        ld_c1 = 12; ld_v1 = 16'h2222; ld_p1 = 4'h0;
        run_frame("frC", 8'h71, 8'h5B, 8'hF7, 8'h06, 1'b1, 20);

        bus.Lz_en = 1'b1;
        ld_n = 1; ld_c0 = 10; ld_v0 = 16'h0070; ld_p0 = 4'h0;
        run_frame("frD", 8'h5B, 8'h5B, 8'h5B, 8'h5B, 1'b1, 20);

        // Load coincident with the boundary: 0070 is shown, 0000 stays pending
        ld_n = 1; ld_c0 = 0; ld_v0 = 16'h0000; ld_p0 = 4'h0;
        run_frame("frE", 8'h3F, 8'h07, 8'h00, 8'h00, 1'b1, 20);

        run_frame("frF", 8'h3F, 8'h00, 8'h00, 8'h00, 1'b1, 20);

        bus.Lz_en = 1'b0;
        run_frame("frG", 8'h3F, 8'h3F, 8'h3F, 8'h3F, 1'b1, 13);

        bus.En = 1'b0; bus.Load = 1'b1; bus.Data_in = 16'h8888; bus.Dp_in = 4'b0001;
        tick();
        bus.Load = 1'b0;
        chk("en_off dig_sel", 16'(bus.Dig_sel), 16'hF);
        chk("en_off seg", 16'(bus.Seg), 16'h00);
        chk("en_off digit_idx", 16'(bus.Digit_idx), 16'h0);
        chk("en_off frame_done", 16'(bus.Frame_done), 16'h0);
        chk("en_off pending", 16'(bus.Pending), 16'h1);
        tick();
        chk("en_off xfer pending", 16'(bus.Pending), 16'h0);
        chk("en_off xfer dig_sel", 16'(bus.Dig_sel), 16'hF);
        tick();
        chk("en_off dark seg", 16'(bus.Seg), 16'h00);
        chk("en_off dark frame_done", 16'(bus.Frame_done), 16'h0);
        tb_pend = 1'b0;

        bus.En = 1'b1;
        run_frame("frH", 8'hFF, 8'h7F, 8'h7F, 8'h7F, 1'b0, 20);

        ld_n = 1; ld_c0 = 2; ld_v0 = 16'h1234; ld_p0 = 4'h0;
        run_frame("frI", 8'hFF, 8'h7F, 8'h7F, 8'h7F, 1'b1, 8);

        Reset = 1'b1;
        tick();
        chk_reset("mid_reset");
        bus.Load = 1'b1; bus.Data_in = 16'h5555; bus.Dp_in = 4'hF;
        tick();
        bus.Load = 1'b0;
        chk_reset("reset_load");
        tb_pend = 1'b0;

        Reset = 1'b0;
        run_frame("frJ", 8'h3F, 8'h3F, 8'h3F, 8'h3F, 1'b0, 20);
        run_frame("frK", 8'h3F, 8'h3F, 8'h3F, 8'h3F, 1'b1, 2);

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end
endmodule

// File: doc/lzy_scan_ctrl.md
Name: lzy_scan_ctrl

Overview:
Time-multiplexed scan controller for a 4-digit common-cathode seven-segment display. It sequences digit selection and per-digit segment data, and encodes segments internally with the standard hex table (0-F). It double-buffers the displayed value so updates apply only at frame boundaries, which prevents tearing. It inserts inter-digit blanking to suppress ghosting and optionally suppresses leading zeros.

Parameters:
DIV, 50000, Clk cycles each digit is driven (SHOW time); legal range >= 1
BLANK_CYC, 2, Clk cycles all digits are off between digits (BLANK time); legal range >= 1

Ports:
Clk  input  1  system clock; all logic on rising edge
Reset  input  1  synchronous, active-high reset
En  input  1  scan enable; 0 = display dark
Load  input  1  1-cycle strobe: capture Data_in/Dp_in into the shadow register
Data_in  input  16  four BCD/hex nibbles; [3:0] = digit 0 (rightmost), [15:12] = digit 3
Dp_in  input  4  decimal point per digit; bit i belongs to digit i
Lz_en  input  1  leading-zero suppression enable; sampled continuously
Seg  output  8  segments, active-high; [6:0] = g..a, [7] = dp
Dig_sel  output  4  digit enables, active-low, one-hot-low when lit
Digit_idx  output  2  index of the current digit
Pending  output  1  shadow holds data not yet displayed
Frame_done  output  1  1-cycle pulse at the end of each frame

Behaviour:
- Registers: active {data 16b, dp 4b}; shadow {data, dp}; Pending; state in {IDLE, BLANK, SHOW}; idx 2b; cycle counter wide enough for max(DIV, BLANK_CYC).
- All outputs are registered.
- Reset (synchronous, active-high, overrides everything): state = IDLE, idx = 0, counter = 0, active = 0, shadow = 0, Pending = 0, Seg = 8'h00, Dig_sel = 4'b1111, Digit_idx = 0, Frame_done = 0.
- IDLE:
  - Seg = 0, Dig_sel = 4'b1111.
  - When En = 1, the next state is BLANK with idx = 0 and counter = 0.
- BLANK:
  - Seg = 0, Dig_sel = 4'b1111, Digit_idx = idx.
  - Lasts exactly BLANK_CYC cycles, then goes to SHOW with the counter cleared.
- SHOW:
  - Dig_sel[idx] = 0, all other bits 1; Seg = encode(idx).
  - Lasts exactly DIV cycles.
  - On exit with idx < 3: idx increments and the state goes to BLANK.
  - On exit with idx = 3: idx = 0, state goes to BLANK, Frame_done = 1 for exactly one cycle.
- Frame boundary (the edge that leaves SHOW with idx = 3): if Pending = 1, active <= shadow and Pending <= 0.
- Frame period = 4*(BLANK_CYC+DIV) cycles.
- Load:
  - On the edge where Load = 1, shadow <= {Data_in, Dp_in} and Pending <= 1.
  - A later Load before the boundary overwrites the shadow (last wins).
  - Load coincident with the frame boundary: the boundary transfers the pre-edge shadow. The new data lands in the shadow and Pending stays 1.
- Load with En = 0: data is captured into the shadow. While En = 0, Pending also transfers immediately to active on the next cycle, so a restart shows the latest data.
- En falls in any state: next cycle state = IDLE, display dark, idx = 0, counter = 0. Active, shadow and Pending are retained except as described for En = 0 above. No Frame_done pulse is generated.
- encode(i): 7-segment hex table, active-high, g..a:
  - 0=3F, 1=06, 2=5B, 3=4F, 4=66, 5=6D, 6=7D, 7=07
  - 8=7F, 9=6F, A=77, B=7C, C=39, D=5E, E=79, F=71
  - Seg[7] = active dp[i].
- Leading-zero suppression (Lz_en = 1) sets segments [6:0] = 0 for:
  - digit 3 if nib3 = 0;
  - digit 2 if nib3 = nib2 = 0;
  - digit 1 if nib3 = nib2 = nib1 = 0.
  - Digit 0 is never suppressed. Dp is still shown on suppressed digits. Dig_sel is still driven normally.
- Simultaneous Reset and Load: Reset wins and nothing is captured.

Test Plan:
- DIV=4, BLANK_CYC=1, Reset 2 cycles, En=1 -> Dig_sel sequence per 5-cycle slot: 1111 then 1110 x4, then 1101, 1011, 0111. Frame_done pulses every 20 cycles. Seg = 3F during SHOW (active = 0).
- Load Data_in=16'h1A2F, Dp_in=4'b0100 mid-frame -> Pending=1 until the frame boundary, then 0. Next frame SHOW Seg: digit0=71, digit1=5B, digit2=F7 (77 with dp), digit3=06.
- Two Loads in one frame (16'h1111 then 16'h2222) -> only 2222 is displayed next frame; 1111 never appears.
- Lz_en=1, Data_in=16'h0070 -> digit3 and digit2 Seg=00 while Dig_sel still strobes; digit1 Seg=07; digit0 Seg=3F. With Data_in=0, only digit0 is lit (3F).
- En deasserted during SHOW of digit 2 -> next cycle Dig_sel=1111 and Seg=00. Re-assert -> restart from BLANK of digit 0; no Frame_done pulse is emitted for the partial frame.
- Reset asserted mid-SHOW while Pending=1 -> next cycle all outputs at reset values and Pending=0. After release with En=1, digit0 shows 3F.
